switch_conditioner: RTL and testbench
=====================================

Name: switch_conditioner

Overview:
- Conditions the three raw slide switches before they reach the switch-to-colour pixel stage that drives the OLED.
- Each switch is synchronised to CLK, then debounced.
- Qualified switch levels reach that stage only on frame boundaries, so a mode change never tears a frame.
- Sits between the top-level switch pins and the pixel-colour stage; runs in the OLED clock domain.

Parameters:
- DEBOUNCE_CYCLES, 62500, cycles a synchronised level must hold before acceptance (10 ms at 6.25 MHz); legal range 2..2^20.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- FRAME_ALIGN, 1, 1 = outputs update only on frame_begin; 0 = outputs follow the debounced level directly.

Ports:
- CLK  in  1  OLED pixel clock; all logic on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- sw_raw  in  3  raw switch pins, bit0 = switch 1; asynchronous to CLK.
- frame_begin  in  1  one-cycle pulse from the OLED driver at the start of each frame.
- SW1  out  1  conditioned switch 1; registered.
- SW2  out  1  conditioned switch 2; registered.
- SW3  out  1  conditioned switch 3; registered.
- sw_change  out  1  one-cycle pulse when any of SW1..SW3 changes value; registered.

Behaviour:
- Reset (RST_N low, asynchronous):
  - sync flops s1/s2, stable[2:0], all counters, SW1..SW3 and sw_change go to 0 immediately.
  - Release is synchronous to CLK with no extra gating.
- Synchroniser: per bit, s1 <= sw_raw, then s2 <= s1; two-flop chain.
- Debounce, independent per bit i, at each edge:
  - s2[i] == stable[i]: cnt[i] <= 0.
  - s2[i] != stable[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - s2[i] != stable[i] and cnt[i] == DEBOUNCE_CYCLES-1: stable[i] <= s2[i], cnt[i] <= 0.
  - Any bounce back to stable[i] before acceptance restarts the count from 0.
- Latency, with raw held constant from edge k: s1 at k, s2 at k+1, stable updates at edge k+1+DEBOUNCE_CYCLES.
- Output stage, FRAME_ALIGN=1:
  - On an edge where frame_begin=1, {SW3,SW2,SW1} <= stable, using the pre-edge value of stable.
  - If stable updates on the same edge as frame_begin, the outputs take the old value; the new value lands at the next frame_begin.
  - Otherwise outputs hold.
- Output stage, FRAME_ALIGN=0: {SW3,SW2,SW1} <= stable every edge, i.e. one cycle behind stable.
- sw_change:
  - Pulses 1 for exactly the cycle after the edge on which {SW3,SW2,SW1} took a different value; else 0.
  - No pulse when a frame_begin reloads an identical value.
- Multiple switches: bits qualify independently.
  - If two bits qualify in different cycles within one frame, both appear together at the next frame_begin with a single sw_change pulse.
- frame_begin held high for several cycles: each such edge reloads; this is harmless, and sw_change fires only on actual change.
- No priority resolution here; the downstream stage applies SW1 > SW2 > SW3 priority. Outputs are raw qualified levels.
- Reset mid-debounce: any partial count is discarded, and the bit must re-qualify from zero after release.
- Counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.

Test Plan:
1. Reset then steady input: DEBOUNCE_CYCLES=4, FRAME_ALIGN=0; assert RST_N=0 with sw_raw=3'b111 → SW1..SW3=0 and sw_change=0 throughout reset. After release, stable=111 at edge 6; SW1..SW3=1 at edge 7; sw_change=1 at edge 8 only.
2. Bounce rejection: DEBOUNCE_CYCLES=4, sw_raw[0] toggles 1,0,1,0 every 2 cycles, then holds 1 → SW1 stays 0 during the toggling. SW1 rises exactly 5 cycles after s2 first settles at 1 (4 for stable, +1 for output register); no intermediate pulse.
3. Frame alignment: FRAME_ALIGN=1, switch 2 qualifies at cycle 50, frame_begin pulses at cycles 40 and 100 → SW2 stays 0 until the edge after cycle 100, then 1. sw_change pulses once.
4. Coincident events: stable[2] updates on the same edge as frame_begin → SW3 unchanged at that frame. SW3=1 after the following frame_begin.
5. Async reset mid-operation: assert RST_N low between clock edges while SW1..SW3=101 and a count is in progress → outputs go 0 without waiting for a clock edge. After release with sw_raw=101, the full DEBOUNCE_CYCLES re-qualification is required before they return.
6. Multi-bit merge: switches 1 and 3 qualify 10 cycles apart within one frame → both outputs change on the same frame_begin, and exactly one sw_change pulse.

Source files
------------

// File: rtl/switch_conditioner_if.sv
// Switch-conditioner signal bundle: raw switch pins and frame strobe in,
// qualified switch levels and change strobe out.
interface switch_conditioner_if;
    logic [2:0] sw_raw;
    logic       frame_begin;
    logic       SW1;
    logic       SW2;
    logic       SW3;
    logic       sw_change;

    modport master (
        output sw_raw,
        output frame_begin,
        input  SW1,
        input  SW2,
        input  SW3,
        input  sw_change
    );

    modport slave (
        input  sw_raw,
        input  frame_begin,
        output SW1,
        output SW2,
        output SW3,
        output sw_change
    );
endinterface

// File: rtl/switch_conditioner.sv
// Synchronises and debounces three slide switches, then releases the qualified
// levels to the pixel-colour stage on frame boundaries so a mode change never tears a frame.
module switch_conditioner #(
    parameter int DEBOUNCE_CYCLES = 62500,
    parameter int CNT_W           = 20,
    parameter int FRAME_ALIGN     = 1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    switch_conditioner_if.slave  sw_if
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic             ALIGN_EN = (FRAME_ALIGN != 32'sd0);

    logic [2:0]       sync1_r;
    logic [2:0]       sync2_r;
    logic [2:0]       stable_r;
    logic [2:0]       stable_nxt_s;
    logic [CNT_W-1:0] cnt_r     [3];
    logic [CNT_W-1:0] cnt_nxt_s [3];
    logic [2:0]       sw_r;
    logic [2:0]       sw_nxt_s;
    logic             change_nxt_s;
    logic             change_pend_r;
    logic             sw_change_r;

    // Two-flop synchroniser for the asynchronous switch pins.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
        end else begin
            sync1_r <= sw_if.sw_raw;
            sync2_r <= sync1_r;
        end
    end

    // Per-bit debounce: any disagreement must persist a full window; a bounce restarts it.
    always_comb begin
        stable_nxt_s = stable_r;
        for (int i = 0; i < 3; i++) begin
            cnt_nxt_s[i] = '0;
            if (sync2_r[i] == stable_r[i]) begin
                cnt_nxt_s[i] = '0;
            end else if (cnt_r[i] >= CNT_MAX) begin
                stable_nxt_s[i] = sync2_r[i];
                cnt_nxt_s[i]    = '0;
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stable_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            stable_r <= stable_nxt_s;
            for (int i = 0; i < 3; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    // Output reload uses the pre-edge stable value, so a coincident qualification waits a frame.
    always_comb begin
        if (!ALIGN_EN) begin
            sw_nxt_s = stable_r;
        end else if (sw_if.frame_begin) begin
            sw_nxt_s = stable_r;
        end else begin
            sw_nxt_s = sw_r;
        end
        change_nxt_s = (sw_nxt_s != sw_r);
    end

    // Output levels; the change strobe lands the cycle after the outputs move.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sw_r          <= 3'b000;
            change_pend_r <= 1'b0;
            sw_change_r   <= 1'b0;
        end else begin
            sw_r          <= sw_nxt_s;
            change_pend_r <= change_nxt_s;
            sw_change_r   <= change_pend_r;
        end
    end

    assign sw_if.SW1       = sw_r[0];
    assign sw_if.SW2       = sw_r[1];
    assign sw_if.SW3       = sw_r[2];
    assign sw_if.sw_change = sw_change_r;

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench: one DUT follows the debounced level, the other releases it on frame_begin.
module tb_switch_conditioner;

    logic CLK;
    logic RST_N;
    int   n_checks;
    int   n_pass;

    switch_conditioner_if ifa ();
    switch_conditioner_if ifb ();

    switch_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .FRAME_ALIGN(0)) dut_a (
        .CLK   (CLK),
        .RST_N (RST_N),
        .sw_if (ifa.slave)
    );

    switch_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .FRAME_ALIGN(1)) dut_b (
        .CLK   (CLK),
        .RST_N (RST_N),
        .sw_if (ifb.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Leaves RST_N released mid-cycle; the next tick is edge 1 after release.
    task automatic do_reset();
        RST_N = 1'b0;
        ifa.sw_raw = 3'b000;
        ifb.sw_raw = 3'b000;
        ifa.frame_begin = 1'b0;
        ifb.frame_begin = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        ifa.sw_raw = 3'b111;
        ifb.sw_raw = 3'b111;
        ifa.frame_begin = 1'b0;
        ifb.frame_begin = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if ({ifa.SW3, ifa.SW2, ifa.SW1, ifa.sw_change} !== 4'b0000)
                $display("FAIL reset_hold cyc %0d: got %b expected 0000", c,
                         {ifa.SW3, ifa.SW2, ifa.SW1, ifa.sw_change});
            else n_pass++;
        end
        RST_N = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick();
            n_checks++;
            if ({ifa.SW3, ifa.SW2, ifa.SW1} !== ((e >= 7) ? 3'b111 : 3'b000))
                $display("FAIL reset_release_sw edge %0d: got %b expected %b", e,
                         {ifa.SW3, ifa.SW2, ifa.SW1}, (e >= 7) ? 3'b111 : 3'b000);
            else n_pass++;
            n_checks++;
            if (ifa.sw_change !== (e == 8))
                $display("FAIL reset_release_chg edge %0d: got %b expected %b", e,
                         ifa.sw_change, (e == 8));
            else n_pass++;
        end
    endtask

    task automatic test_bounce();
        logic b;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            b = (p % 2 == 0);
            ifa.sw_raw = {2'b00, b};
            for (int k = 0; k < 2; k++) begin
                tick();
                n_checks++;
                if ({ifa.SW1, ifa.sw_change} !== 2'b00)
                    $display("FAIL bounce_reject phase %0d: got %b expected 00", p,
                             {ifa.SW1, ifa.sw_change});
                else n_pass++;
            end
        end
        ifa.sw_raw = 3'b001;
        for (int t = 1; t <= 9; t++) begin
            tick();
            n_checks++;
            if (ifa.SW1 !== (t >= 7))
                $display("FAIL bounce_settle_sw t %0d: got %b expected %b", t, ifa.SW1, (t >= 7));
            else n_pass++;
            n_checks++;
            if (ifa.sw_change !== (t == 8))
                $display("FAIL bounce_settle_chg t %0d: got %b expected %b", t, ifa.sw_change, (t == 8));
            else n_pass++;
        end
    endtask

    task automatic test_frame_align();
        do_reset();
        for (int c = 1; c <= 104; c++) begin
            ifb.frame_begin = (c == 40 || c == 100);
            if (c == 45) ifb.sw_raw = 3'b010;
            tick();
            n_checks++;
            if ({ifb.SW3, ifb.SW2, ifb.SW1} !== ((c >= 100) ? 3'b010 : 3'b000))
                $display("FAIL frame_align_sw cyc %0d: got %b expected %b", c,
                         {ifb.SW3, ifb.SW2, ifb.SW1}, (c >= 100) ? 3'b010 : 3'b000);
            else n_pass++;
            n_checks++;
            if (ifb.sw_change !== (c == 101))
                $display("FAIL frame_align_chg cyc %0d: got %b expected %b", c, ifb.sw_change, (c == 101));
            else n_pass++;
        end
        ifb.frame_begin = 1'b0;
    endtask

    task automatic test_coincident();
        do_reset();
        for (int c = 1; c <= 33; c++) begin
            ifb.frame_begin = (c == 20 || c == 30);
            if (c == 15) ifb.sw_raw = 3'b100;
            tick();
            n_checks++;
            if (ifb.SW3 !== (c >= 30))
                $display("FAIL coincident_sw3 cyc %0d: got %b expected %b", c, ifb.SW3, (c >= 30));
            else n_pass++;
            n_checks++;
            if (ifb.sw_change !== (c == 31))
                $display("FAIL coincident_chg cyc %0d: got %b expected %b", c, ifb.sw_change, (c == 31));
            else n_pass++;
        end
        ifb.frame_begin = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        ifa.sw_raw = 3'b101;
        for (int c = 0; c < 10; c++) tick();
        n_checks++;
        if ({ifa.SW3, ifa.SW2, ifa.SW1} !== 3'b101)
            $display("FAIL async_pre_sw: got %b expected 101", {ifa.SW3, ifa.SW2, ifa.SW1});
        else n_pass++;
        ifa.sw_raw = 3'b111;
        for (int c = 0; c < 4; c++) tick();
        #2;
        RST_N = 1'b0;
        #1;
        n_checks++;
        if ({ifa.SW3, ifa.SW2, ifa.SW1, ifa.sw_change} !== 4'b0000)
            $display("FAIL async_immediate: got %b expected 0000",
                     {ifa.SW3, ifa.SW2, ifa.SW1, ifa.sw_change});
        else n_pass++;
        ifa.sw_raw = 3'b101;
        tick();
        tick();
        RST_N = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            n_checks++;
            if ({ifa.SW3, ifa.SW2, ifa.SW1} !== ((e >= 7) ? 3'b101 : 3'b000))
                $display("FAIL async_requal_sw edge %0d: got %b expected %b", e,
                         {ifa.SW3, ifa.SW2, ifa.SW1}, (e >= 7) ? 3'b101 : 3'b000);
            else n_pass++;
            n_checks++;
            if (ifa.sw_change !== (e == 8))
                $display("FAIL async_requal_chg edge %0d: got %b expected %b", e, ifa.sw_change, (e == 8));
            else n_pass++;
        end
    endtask

    // Bits 0 and 2 qualify 10 cycles apart, then frame_begin is held high across identical reloads.
    task automatic test_multi_bit();
        do_reset();
        for (int c = 1; c <= 56; c++) begin
            ifb.frame_begin = (c == 10 || c == 40 || (c >= 50 && c <= 52));
            if (c == 11) ifb.sw_raw = 3'b001;
            if (c == 21) ifb.sw_raw = 3'b101;
            tick();
            n_checks++;
            if ({ifb.SW3, ifb.SW2, ifb.SW1} !== ((c >= 40) ? 3'b101 : 3'b000))
                $display("FAIL multi_bit_sw cyc %0d: got %b expected %b", c,
                         {ifb.SW3, ifb.SW2, ifb.SW1}, (c >= 40) ? 3'b101 : 3'b000);
            else n_pass++;
            n_checks++;
            if (ifb.sw_change !== (c == 41))
                $display("FAIL multi_bit_chg cyc %0d: got %b expected %b", c, ifb.sw_change, (c == 41));
            else n_pass++;
        end
        ifb.frame_begin = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        RST_N    = 1'b0;
        ifa.sw_raw = 3'b000;
        ifb.sw_raw = 3'b000;
        ifa.frame_begin = 1'b0;
        ifb.frame_begin = 1'b0;
        test_reset();
        test_bounce();
        test_frame_align();
        test_coincident();
        test_async_reset();
        test_multi_bit();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
